// File: rtl/jt49_mixn_pkg.sv
// Shared constants and width helpers for the N-channel PSG output mixer.
// Slot counter and sum widths are derived from the channel count.
// Pan bit positions inside each channel's 2-bit pan field.
package jt49_mixn_pkg;

  localparam int PAN_L = 0;
  localparam int PAN_R = 1;

  // Slot counter must hold 0..CH inclusive.
  function automatic int slot_w(input int ch);
    return $clog2(ch + 1);
  endfunction

  // Width that holds 255*CH without overflow.
  function automatic int sum_w(input int ch);
    return 8 + $clog2(ch);
  endfunction

endpackage

// File: rtl/jt49_exp.sv
// Registered 5-bit log to 8-bit linear volume table with selectable curve.
// Latency: 1 clk, updates every clk regardless of clock enable.
// No backpressure; consumer samples dout once it has settled.
module jt49_exp (
  input  logic       clk,
  input  logic [1:0] comp,
  input  logic [4:0] din,
  output logic [7:0] dout
);

  // Entry k sits at bits [8k+7:8k]; every curve maps 0->0 and 31->255.
  localparam logic [255:0] LUT0 =
    256'hFFD6B4977F6B5A4B3F352D251F1A1613_100D0B09070605040303020201010100;
  localparam logic [255:0] LUT1 =
    256'hFFD9B7A18D7C6D60544A4139322C2621_1D191613100E0C0A0807060504030200;

  logic [7:0] w_bit;
  logic [7:0] w_val;

  assign w_bit = {din, 3'b000};

  // Curve select: 0 steep, 1 softer, 2 linear ramp, 3 reuses the steep curve.
  always_comb begin
    w_val = LUT0[w_bit +: 8];
    case (comp)
      2'b01:   w_val = LUT1[w_bit +: 8];
      2'b10:   w_val = {din, 3'b000} + {5'b00000, din[4:2]};
      default: w_val = LUT0[w_bit +: 8];
    endcase
  end

  // Register the table output.
  always_ff @(posedge clk) begin
    dout <= w_val;
  end

endmodule

// File: rtl/jt49_mixn.sv
// N-channel PSG output stage: frame snapshot, shared exp table, mono/stereo sums.
// Latency: sums appear CH+1 cens after the snapshot; ch_lin[k] k+1 cens after it.
// No backpressure; sample pulses one clk at every frame start (slot 0 cen).
module jt49_mixn
  import jt49_mixn_pkg::*;
#(
  parameter int         CH   = 3,
  parameter logic [1:0] COMP = 2'b00,
  parameter int         SW   = sum_w(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic [5*CH-1:0] log_in,
  input  logic [CH-1:0]   mute,
  input  logic [2*CH-1:0] pan,
  output logic [8*CH-1:0] ch_lin,
  output logic [SW-1:0]   sound,
  output logic [SW-1:0]   left,
  output logic [SW-1:0]   right,
  output logic            sample
);

  localparam int SLW = slot_w(CH);

  logic [SLW-1:0]  r_slot;
  logic [5*CH-1:0] r_snap_log;
  logic [CH-1:0]   r_snap_mute;
  logic [2*CH-1:0] r_snap_pan;
  logic [SW-1:0]   r_acc_m;
  logic [SW-1:0]   r_acc_l;
  logic [SW-1:0]   r_acc_r;
  logic [8*CH-1:0] r_ch_lin;
  logic [SW-1:0]   r_sound;
  logic [SW-1:0]   r_left;
  logic [SW-1:0]   r_right;
  logic            r_sample;

  logic [SLW-1:0]  w_cur;
  logic [4:0]      w_exp_din;
  logic [7:0]      w_exp_dout;
  logic            w_mute_cur;
  logic [1:0]      w_pan_cur;
  logic [7:0]      w_lin;

  // Channel served in slot s is s-1; at slot 0 this wraps to a value no channel matches.
  assign w_cur = r_slot - SLW'(1);

  // Pick the snapshot fields of the channel currently in service.
  always_comb begin
    w_exp_din  = '0;
    w_mute_cur = 1'b0;
    w_pan_cur  = '0;
    for (int k = 0; k < CH; k++) begin
      if (w_cur == SLW'(k)) begin
        w_exp_din  = r_snap_log[5*k +: 5];
        w_mute_cur = r_snap_mute[k];
        w_pan_cur  = r_snap_pan[2*k +: 2];
      end
    end
  end

  // The table registers every clk; the idle clk between cens lets it settle.
  jt49_exp u_exp (
    .clk  (clk),
    .comp (COMP),
    .din  (w_exp_din),
    .dout (w_exp_dout)
  );

  assign w_lin = w_mute_cur ? 8'd0 : w_exp_dout;

  // Slot sequencing, snapshot capture, accumulation and output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot      <= '0;
      r_snap_log  <= '0;
      r_snap_mute <= '0;
      r_snap_pan  <= '0;
      r_acc_m     <= '0;
      r_acc_l     <= '0;
      r_acc_r     <= '0;
      r_ch_lin    <= '0;
      r_sound     <= '0;
      r_left      <= '0;
      r_right     <= '0;
      r_sample    <= 1'b0;
    end else begin
      r_sample <= 1'b0;
      if (cen) begin
        r_slot <= (r_slot == SLW'(CH)) ? '0 : r_slot + SLW'(1);
        if (r_slot == '0) begin
          r_snap_log  <= log_in;
          r_snap_mute <= mute;
          r_snap_pan  <= pan;
          r_sound     <= r_acc_m;
          r_left      <= r_acc_l;
          r_right     <= r_acc_r;
          r_acc_m     <= '0;
          r_acc_l     <= '0;
          r_acc_r     <= '0;
          r_sample    <= 1'b1;
        end else begin
          for (int k = 0; k < CH; k++) begin
            if (w_cur == SLW'(k)) begin
              r_ch_lin[8*k +: 8] <= w_lin;
            end
          end
          r_acc_m <= r_acc_m + SW'(w_lin);
          if (w_pan_cur[PAN_L]) begin
            r_acc_l <= r_acc_l + SW'(w_lin);
          end
          if (w_pan_cur[PAN_R]) begin
            r_acc_r <= r_acc_r + SW'(w_lin);
          end
        end
      end
    end
  end

  assign ch_lin = r_ch_lin;
  assign sound  = r_sound;
  assign left   = r_left;
  assign right  = r_right;
  assign sample = r_sample;

endmodule

// File: doc/jt49_mixn.md
Name: jt49_mixn

Overview:
- Parametrised N-channel output stage for the PSG family: frame-coherent snapshot of per-channel 5-bit log volumes, conversion through one shared registered exp table, per-channel linear outputs, and mono plus stereo sums.
- Generalises the fixed 3-channel round-robin accumulator to CH channels, with per-channel mute, L/R pan and a sample-valid strobe.
- Sits between the tone/noise/envelope mixing logic and the top-level sound outputs.

Parameters:
- CH, 3, number of channels (1..16).
- COMP, 2'b00, compression curve selector passed to the exp table.
- SW, 8+$clog2(CH), sum width; derived, not to be overridden. CH=3 gives 10, CH=1 gives 8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- cen  in  1  clock enable; all state advances only when high.
- log_in  in  5*CH  channel k log volume at bits [5k+4:5k]; 0 means silent, 31 means maximum.
- mute  in  CH  1 forces the channel to contribute 0.
- pan  in  2*CH  channel k: bit 2k enables left, bit 2k+1 enables right.
- ch_lin  out  8*CH  linear value per channel, same packing as log_in.
- sound  out  SW  mono sum of all unmuted channels.
- left  out  SW  sum of unmuted, left-enabled channels.
- right  out  SW  sum of unmuted, right-enabled channels.
- sample  out  1  one-clk pulse, coincident with a cen, marking new sound/left/right.

Behaviour:
- Reset (async, rst=1): slot=0; snapshots, accumulators, ch_lin, sound, left, right = 0; sample=0. Release takes effect on the first cen.
- Frame: a slot counter runs 0..CH, so a frame is CH+1 cen cycles; it wraps CH->0. When cen=0 everything holds and sample=0.
- Slot 0 (on cen):
  - Snapshot log_in, mute and pan for all channels. Changes mid-frame do not affect the current frame.
  - Load sound/left/right from the accumulators, then clear the accumulators.
  - Assert sample for that clk.
  - Present snapshot channel 0 to the exp table.
- Slot s (1..CH, on cen):
  - lin = exp table output for channel s-1, forced to 0 if that channel's snapshot mute=1.
  - Write ch_lin[s-1] = lin.
  - acc_m += lin; acc_l += lin if pan L; acc_r += lin if pan R.
  - If s<CH, present channel s to the exp table.
- Exp table: registered, 1-clk latency. cen must be at most 1-in-2 clk. Slot spacing guarantees the output is settled.
- Latency:
  - Snapshot at slot 0 of frame n appears on sound/left/right at slot 0 of frame n+1, i.e. CH+1 cens later.
  - ch_lin[k] updates k+1 cens after the snapshot.
- Width: accumulators are SW bits. The maximum 255*CH always fits, so no saturation or wrap is possible.
- Pan 2'b00: the channel contributes to sound only. Pan 2'b11: it contributes to both left and right.
- CH=1: two-slot frame; sample fires every 2nd cen.
- Reset mid-frame: partial accumulators are discarded; the first valid sample arrives CH+1 cens after the first post-reset slot 0.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package: the slot-count width function ($clog2(CH+1)), the SW derivation, and the pan bit positions (PAN_L=0, PAN_R=1).
- Sub-module: reuse jt49_exp as the single instantiated shared exp table (COMP wired through).
- Everything else (slot counter, snapshot registers, three accumulators) stays in this block.

Test Plan:
- CH=3, COMP=0, cen every 2nd clk. log_in all 31, mute 0, pan 2'b11 -> after the second sample: sound=left=right=765, each ch_lin=255.
- CH=3, log_in ch0=31, ch1=31, ch2=0, pan ch0=01, ch1=10 -> sound=510, left=255, right=255, ch_lin[2]=0.
- CH=3, all 31, mute=3'b010 -> sound=510 and ch_lin[1]=0 from the next full frame. Toggle mute at slot 2 -> no effect until the following snapshot.
- CH=8, all 31, pan 11 -> SW=11, sound=2040 with no wrap. sample period = 9 cens; check that the pulse is exactly 1 clk wide.
- CH=1, log_in=31 -> sample every 2 cens, sound=255. Hold cen=0 for 20 clks -> outputs and slot are frozen, no sample.
- Assert rst at slot 2 with the accumulators non-zero -> all outputs 0 immediately. After release, the first sample shows 0, and correct sums appear CH+1 cens later.
